// File: rtl/hex_counter_ctrl_if.sv
// Board-side signals of the hex counter: slide switches, push-buttons and the
// two seven-segment displays plus the run indicator.
interface hex_counter_ctrl_if;
    logic [7:0] inputs;
    logic       load_n;
    logic       start_stop_n;
    logic       up_down;
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic       running;

    modport master (
        output inputs, load_n, start_stop_n, up_down,
        input  hex1, hex0, running
    );

    modport slave (
        input  inputs, load_n, start_stop_n, up_down,
        output hex1, hex0, running
    );
endinterface

// File: rtl/hex_counter_ctrl.sv
// Two-digit hex up/down counter with run/stop and load buttons, stepping once
// every PRESCALE clocks while running and driving active-low 7-segment digits.
module hex_counter_ctrl #(
    parameter int unsigned PRESCALE = 50_000_000
) (
    input logic              clock,
    input logic              reset,
    hex_counter_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q;
    logic          running_q;
    logic [7:0]    count_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    load_sync_q;
    logic [1:0]    ss_sync_q;
    logic [1:0]    dir_sync_q;
    logic          load_prev_q;
    logic          ss_prev_q;

    logic load_press;
    logic ss_press;
    logic tick;

    // A press is a falling edge of the synchronized level.
    assign load_press = load_prev_q & ~load_sync_q[1];
    assign ss_press   = ss_prev_q & ~ss_sync_q[1];
    assign tick       = (state_q == StRun) && (presc_q == PRESC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            running_q   <= 1'b0;
            count_q     <= 8'h00;
            presc_q     <= '0;
            load_sync_q <= 2'b11;
            ss_sync_q   <= 2'b11;
            dir_sync_q  <= 2'b11;
            load_prev_q <= 1'b1;
            ss_prev_q   <= 1'b1;
        end else begin
            load_sync_q <= {load_sync_q[0], bus.load_n};
            ss_sync_q   <= {ss_sync_q[0], bus.start_stop_n};
            dir_sync_q  <= {dir_sync_q[0], bus.up_down};
            load_prev_q <= load_sync_q[1];
            ss_prev_q   <= ss_sync_q[1];

            if (ss_press) begin
                state_q   <= (state_q == StIdle) ? StRun : StIdle;
                running_q <= (state_q == StIdle);
            end

            // Load beats a coincident tick.
            if (load_press) begin
                count_q <= bus.inputs;
            end else if (tick) begin
                count_q <= dir_sync_q[1] ? count_q + 8'd1 : count_q - 8'd1;
            end

            if (load_press || ss_press || state_q == StIdle || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h7F;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        bus.hex1    = seg7(count_q[7:4]);
        bus.hex0    = seg7(count_q[3:0]);
        bus.running = running_q;
    end
endmodule
